// File: rtl/debug_frame_rx_pkg.sv
// debug_frame_rx_pkg
//   Shared constants for the debug frame receiver: default sync word, frame
//   body length, CRC-16/CCITT-FALSE polynomial and seed, byte positions inside
//   the frame body, FSM state encodings, and the one-byte CRC update function.
//   Build option: DEBUG_FRAME_RX_CRC_EN adds the two trailing CRC bytes to the
//   frame body.
package debug_frame_rx_pkg;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'h5AA5;

`ifdef DEBUG_FRAME_RX_CRC_EN
  localparam int BODY_LEN = 9;
`else
  localparam int BODY_LEN = 7;
`endif
  localparam int IDX_W = $clog2(BODY_LEN);

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int IDX_CMD     = 0;
  localparam int IDX_ADDR_HI = 1;
  localparam int IDX_ADDR_LO = 2;
  localparam int IDX_DATA_3  = 3;
  localparam int IDX_DATA_2  = 4;
  localparam int IDX_DATA_1  = 5;
  localparam int IDX_DATA_0  = 6;
  localparam int IDX_CRC_HI  = 7;
  localparam int IDX_CRC_LO  = 8;

  localparam logic [1:0] ST_HUNT0 = 2'd0;
  localparam logic [1:0] ST_HUNT1 = 2'd1;
  localparam logic [1:0] ST_BODY  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  // One byte of CRC-16/CCITT-FALSE, MSB first, no reflection.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc_in,
                                             input logic [7:0]  byte_in);
    logic [15:0] c;
    c = crc_in ^ {byte_in, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/debug_crc16_ccitt.sv
// debug_crc16_ccitt
//   Combinational next-CRC for CRC-16/CCITT-FALSE, one byte per evaluation.
//   Ports:
//     crc_in  [15:0]  running CRC before this byte
//     byte_in [7:0]   byte to fold in
//     crc_out [15:0]  running CRC after this byte
module debug_crc16_ccitt
  import debug_frame_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  assign crc_out = crc16_next(crc_in, byte_in);

endmodule

// File: rtl/debug_frame_rx.sv
// debug_frame_rx
//   Byte-stream frame receiver between the debug UART and the debug
//   coprocessor command decoder. Hunts for the 2-byte sync word, collects
//   CMD, ADDR[15:0], DATA[31:0] (optionally a CRC16), and presents the frame
//   on a valid/ready handshake.
//   Build option: DEBUG_FRAME_RX_CRC_EN enables the trailing CRC16 and the
//   crc_error pulse; without it every complete frame is accepted and
//   crc_error is held at 0.
//   Ports:
//     clk, reset_n          clock, synchronous active-low reset
//     rx_valid, rx_data     one-cycle strobe with the received byte
//     frame_valid/ready     output handshake for frame_cmd/addr/data
//     crc_error             pulse: frame dropped on CRC mismatch
//     timeout_error         pulse: partial frame abandoned (inter-byte gap)
//     overrun_error         pulse: new frame dropped, previous still held
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   HUNT0    | waiting for the sync high byte
//   HUNT1    | sync high seen, waiting for the sync low byte
//   BODY     | collecting body bytes by index
//   CHECK    | one cycle: verify CRC, load outputs or flag an error
module debug_frame_rx
  import debug_frame_rx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 200000,
  parameter int          TIMEOUT_WIDTH  = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [7:0]  frame_cmd,
  output logic [15:0] frame_addr,
  output logic [31:0] frame_data,
  output logic        crc_error,
  output logic        timeout_error,
  output logic        overrun_error
);

  localparam logic [7:0] SYNC_HI = SYNC_WORD[15:8];
  localparam logic [7:0] SYNC_LO = SYNC_WORD[7:0];

  logic [1:0]               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [7:0]               body_q [BODY_LEN];
  logic [7:0]               body_d [BODY_LEN];
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     frame_valid_q, frame_valid_d;
  logic [7:0]               cmd_q, cmd_d;
  logic [15:0]              addr_q, addr_d;
  logic [31:0]              data_q, data_d;
  logic                     to_err_q, to_err_d;
  logic                     ovr_err_q, ovr_err_d;
  logic                     counting;
  logic                     crc_ok;

`ifdef DEBUG_FRAME_RX_CRC_EN
  logic [15:0] crc_q, crc_d, crc_next;
  logic        crc_err_q, crc_err_d;

  debug_crc16_ccitt u_crc (
    .crc_in  (crc_q),
    .byte_in (rx_data),
    .crc_out (crc_next)
  );

  // CRC bytes are excluded from the running CRC, so crc_q is the final value.
  assign crc_ok    = (crc_q == {body_q[IDX_CRC_HI], body_q[IDX_CRC_LO]});
  assign crc_error = crc_err_q;
`else
  assign crc_ok    = 1'b1;
  assign crc_error = 1'b0;
`endif

  assign counting = (state_q == ST_HUNT1) || (state_q == ST_BODY);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    body_d        = body_q;
    cnt_d         = '0;
    frame_valid_d = frame_valid_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    data_d        = data_q;
    to_err_d      = 1'b0;
    ovr_err_d     = 1'b0;
`ifdef DEBUG_FRAME_RX_CRC_EN
    crc_d         = crc_q;
    crc_err_d     = 1'b0;
`endif

    if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;

    // A byte in the expiry cycle wins: the case below handles it instead.
    if (counting && !rx_valid) begin
      if (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
        to_err_d = 1'b1;
        state_d  = ST_HUNT0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_HUNT0: begin
        if (rx_valid && (rx_data == SYNC_HI)) state_d = ST_HUNT1;
      end
      ST_HUNT1: begin
        if (rx_valid) begin
          if (rx_data == SYNC_LO) begin
            state_d = ST_BODY;
            idx_d   = '0;
`ifdef DEBUG_FRAME_RX_CRC_EN
            crc_d   = CRC_INIT;
`endif
          end else if (rx_data != SYNC_HI) begin
            state_d = ST_HUNT0;
          end
        end
      end
      ST_BODY: begin
        if (rx_valid) begin
          body_d[idx_q] = rx_data;
`ifdef DEBUG_FRAME_RX_CRC_EN
          if (idx_q < IDX_W'(IDX_CRC_HI)) crc_d = crc_next;
`endif
          if (idx_q == IDX_W'(BODY_LEN - 1)) state_d = ST_CHECK;
          else                               idx_d   = idx_q + 1'b1;
        end
      end
      default: begin
        if (!crc_ok) begin
`ifdef DEBUG_FRAME_RX_CRC_EN
          crc_err_d = 1'b1;
`endif
        end else if (frame_valid_q) begin
          ovr_err_d = 1'b1;
        end else begin
          frame_valid_d = 1'b1;
          cmd_d  = body_q[IDX_CMD];
          addr_d = {body_q[IDX_ADDR_HI], body_q[IDX_ADDR_LO]};
          data_d = {body_q[IDX_DATA_3], body_q[IDX_DATA_2],
                    body_q[IDX_DATA_1], body_q[IDX_DATA_0]};
        end
        // CHECK doubles as HUNT0 for a byte arriving right behind the frame.
        state_d = (rx_valid && (rx_data == SYNC_HI)) ? ST_HUNT1 : ST_HUNT0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_HUNT0;
      idx_q         <= '0;
      for (int i = 0; i < BODY_LEN; i++) body_q[i] <= '0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      cmd_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      to_err_q      <= 1'b0;
      ovr_err_q     <= 1'b0;
`ifdef DEBUG_FRAME_RX_CRC_EN
      crc_q         <= CRC_INIT;
      crc_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      body_q        <= body_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      to_err_q      <= to_err_d;
      ovr_err_q     <= ovr_err_d;
`ifdef DEBUG_FRAME_RX_CRC_EN
      crc_q         <= crc_d;
      crc_err_q     <= crc_err_d;
`endif
    end
  end

  assign frame_valid   = frame_valid_q;
  assign frame_cmd     = cmd_q;
  assign frame_addr    = addr_q;
  assign frame_data    = data_q;
  assign timeout_error = to_err_q;
  assign overrun_error = ovr_err_q;

endmodule
